dfp_burst_adapter: RTL and testbench



---
 rtl/dfp_burst_adapter.sv | 177 +++++++++++++++++
 tb/tb_dfp_burst_adapter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_burst_adapter.sv
// Responder for the cache downward-facing port: each 256-bit line read or
// writeback becomes a 4-beat, 64-bit burst on the memory interface.
module dfp_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [31:0]           mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = $clog2(BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_s;
    logic [31:0]             addr_r;
    logic [LINE_WIDTH-1:0]   wdata_r;
    logic [LINE_WIDTH-1:0]   line_r;
    logic [LINE_WIDTH-1:0]   wsrc_s;
    logic [BEAT_WIDTH-1:0]   mem_wdata_s;
    logic [BEAT_WIDTH-1:0]   mem_wdata_r;
    logic                    mem_read_r;
    logic                    mem_write_r;
    logic                    dfp_resp_r;

    // Next-state and beat-counter logic; write wins if both requests are seen.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (dfp_write) begin
                    state_s = WR_DATA;
                end else if (dfp_read) begin
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                cnt_s = {CNT_W{1'b0}};
                if (mem_ready) begin
                    state_s = RD_DATA;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_DATA: begin
                if (mem_rvalid && (cnt_r == LAST_BEAT)) begin
                    state_s = RESP;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (mem_rvalid) begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            WR_DATA: begin
                if (mem_ready && (cnt_r == LAST_BEAT)) begin
                    state_s = RESP;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (mem_ready) begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            RESP: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Next write beat; on the accepting cycle the line still comes straight from the port.
    always_comb begin
        if (state_r == IDLE) begin
            wsrc_s = dfp_wdata;
        end else begin
            wsrc_s = wdata_r;
        end
        if (state_s == WR_DATA) begin
            mem_wdata_s = wsrc_s[int'(cnt_s) * BEAT_WIDTH +: BEAT_WIDTH];
        end else begin
            mem_wdata_s = {BEAT_WIDTH{1'b0}};
        end
    end

    // State, counter and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= 32'd0;
            wdata_r <= {LINE_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if ((state_r == IDLE) && (dfp_write || dfp_read)) begin
                addr_r <= dfp_addr & ADDR_MASK;
            end else begin
                addr_r <= addr_r;
            end
            if ((state_r == IDLE) && dfp_write) begin
                wdata_r <= dfp_wdata;
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    // Read line assembly; the line doubles as dfp_rdata and holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= {LINE_WIDTH{1'b0}};
        end else if ((state_r == RD_DATA) && mem_rvalid) begin
            line_r[int'(cnt_r) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
        end else begin
            line_r <= line_r;
        end
    end

    // Output registers, loaded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_wdata_r <= {BEAT_WIDTH{1'b0}};
            dfp_resp_r  <= 1'b0;
        end else begin
            mem_read_r  <= (state_s == RD_REQ);
            mem_write_r <= (state_s == WR_DATA);
            mem_wdata_r <= mem_wdata_s;
            dfp_resp_r  <= (state_s == RESP);
        end
    end

    assign dfp_rdata = line_r;
    assign dfp_resp  = dfp_resp_r;
    assign mem_addr  = addr_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dfp_burst_adapter.sv
// Directed bench for dfp_burst_adapter: a scripted memory responder per scenario,
// expected values written out by hand.
module tb_dfp_burst_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic [63:0]  mem_rdata;
    logic         mem_rvalid;

    int tests_run    = 0;
    int tests_failed = 0;
    int illegal_cnt  = 0;

    localparam logic [255:0] LINE_A = {64'h4, 64'h3, 64'h2, 64'h1};
    localparam logic [255:0] LINE_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_8765};
    localparam logic [255:0] LINE_C = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
                                       64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    localparam logic [255:0] LINE_D = {64'hD0D0_1111_2222_3333, 64'hD1D1_4444_5555_6666,
                                       64'hD2D2_7777_8888_9999, 64'hD3D3_AAAA_BBBB_CCCC};
    localparam logic [255:0] LINE_E = {64'hE000_0000_0000_00E3, 64'hE000_0000_0000_00E2,
                                       64'hE000_0000_0000_00E1, 64'hE000_0000_0000_00E0};
    localparam logic [255:0] WLINE  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    dfp_burst_adapter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    // Requester must never raise both requests at once.
    always @(posedge clk) begin
        if (dfp_read && dfp_write) illegal_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a line read and plays the memory: ready after ready_lag mem_read cycles,
    // then beats separated by gap idle cycles. abort_beats>0 stops after that many beats.
    task automatic run_read(input logic [31:0] addr, input logic [255:0] line_in,
                            input int ready_lag, input int gap, input int abort_beats,
                            input int linger, output int rd_cycles, output int resp_cycle,
                            output int resp_count, output logic [31:0] addr_seen,
                            output logic [255:0] rdata_seen);
        int beat;
        int idle;
        bit acc;
        beat = 0; idle = 0; acc = 1'b0;
        rd_cycles = 0; resp_cycle = -1; resp_count = 0;
        addr_seen = 32'd0; rdata_seen = 256'd0;
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (mem_read) begin
                rd_cycles++;
                addr_seen = mem_addr;
            end
            if (dfp_resp) begin
                resp_count++;
                resp_cycle = c;
                rdata_seen = dfp_rdata;
                dfp_read = 1'b0;
            end
            if (abort_beats > 0 && beat == abort_beats) break;
            if (resp_count > 0 && c >= resp_cycle + linger) break;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
            if (acc && beat < 4) begin
                if (idle >= gap) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = line_in[beat*64 +: 64];
                    beat++;
                    idle = 0;
                end else begin
                    idle++;
                end
            end
            if (mem_read && rd_cycles > ready_lag) begin
                mem_ready = 1'b1;
                acc = 1'b1;
            end
        end
        dfp_read = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    // Issues a line writeback; memory stalls stall_len cycles before beat stall_beat.
    // Stray read beats are driven throughout to show they are ignored.
    task automatic run_write(input logic [31:0] addr, input logic [255:0] wdata,
                             input int stall_beat, input int stall_len, input int linger,
                             output logic [255:0] wr_seen, output logic [63:0] stall_first,
                             output logic [63:0] stall_last, output int beats_acc,
                             output int resp_cycle, output int resp_count,
                             output logic [31:0] addr_seen, output bit rdata_stable);
        int stalls;
        logic [255:0] rdata0;
        stalls = 0; beats_acc = 0; resp_cycle = -1; resp_count = 0;
        wr_seen = 256'd0; stall_first = 64'd0; stall_last = 64'd0; addr_seen = 32'd0;
        rdata0 = dfp_rdata; rdata_stable = 1'b1;
        dfp_addr = addr; dfp_wdata = wdata; dfp_write = 1'b1; dfp_read = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (dfp_rdata !== rdata0) rdata_stable = 1'b0;
            if (dfp_resp) begin
                resp_count++;
                resp_cycle = c;
                dfp_write = 1'b0;
            end
            if (resp_count > 0 && c >= resp_cycle + linger) break;
            mem_ready = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = {32'hBAD0_0000, 32'(c)};
            if (mem_write) begin
                addr_seen = mem_addr;
                if (beats_acc == stall_beat && stalls < stall_len) begin
                    if (stalls == 0) stall_first = mem_wdata;
                    stall_last = mem_wdata;
                    stalls++;
                end else begin
                    mem_ready = 1'b1;
                    if (beats_acc < 4) wr_seen[beats_acc*64 +: 64] = mem_wdata;
                    beats_acc++;
                end
            end
        end
        dfp_write = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dfp_addr = 32'd0; dfp_read = 1'b0; dfp_write = 1'b0;
        dfp_wdata = 256'd0; mem_ready = 1'b0; mem_rdata = 64'd0; mem_rvalid = 1'b0;
        tick();
        tick();
        tests_run++; if (dfp_rdata !== 256'd0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", dfp_rdata); end
        tests_run++; if (dfp_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_resp: got %b expected 0", dfp_resp); end
        tests_run++; if (mem_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        tests_run++; if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %b expected 0", mem_read); end
        tests_run++; if (mem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b expected 0", mem_write); end
        tests_run++; if (mem_wdata !== 64'd0) begin tests_failed++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_zero_stall();
        int rd, rc, rn;
        logic [31:0] a;
        logic [255:0] l;
        run_read(32'h1234_5678, LINE_A, 0, 0, 0, 2, rd, rc, rn, a, l);
        tests_run++; if (a !== 32'h1234_5660) begin tests_failed++; $display("FAIL rd0_addr: got %h expected 12345660", a); end
        tests_run++; if (rd !== 1) begin tests_failed++; $display("FAIL rd0_read_cycles: got %0d expected 1", rd); end
        tests_run++; if (rc !== 6) begin tests_failed++; $display("FAIL rd0_latency: got %0d expected 6", rc); end
        tests_run++; if (rn !== 1) begin tests_failed++; $display("FAIL rd0_resp_count: got %0d expected 1", rn); end
        tests_run++; if (l !== LINE_A) begin tests_failed++; $display("FAIL rd0_line: got %h expected %h", l, LINE_A); end
    endtask

    task automatic test_write_stall();
        logic [255:0] ws;
        logic [63:0] sf, sl;
        int ba, rc, rn;
        logic [31:0] a;
        bit st;
        run_write(32'h0000_1F3C, WLINE, 1, 2, 2, ws, sf, sl, ba, rc, rn, a, st);
        tests_run++; if (ws !== WLINE) begin tests_failed++; $display("FAIL wr_beats: got %h expected %h", ws, WLINE); end
        tests_run++; if (sf !== 64'hBBBB_BBBB_BBBB_BBBB || sl !== 64'hBBBB_BBBB_BBBB_BBBB) begin tests_failed++; $display("FAIL wr_stall_hold: got %h/%h expected BBBB..", sf, sl); end
        tests_run++; if (ba !== 4) begin tests_failed++; $display("FAIL wr_beat_count: got %0d expected 4", ba); end
        tests_run++; if (rn !== 1) begin tests_failed++; $display("FAIL wr_resp_count: got %0d expected 1", rn); end
        tests_run++; if (rc !== 7) begin tests_failed++; $display("FAIL wr_latency: got %0d expected 7", rc); end
        tests_run++; if (a !== 32'h0000_1F20) begin tests_failed++; $display("FAIL wr_addr: got %h expected 00001f20", a); end
        tests_run++; if (st !== 1'b1 || dfp_rdata !== LINE_A) begin tests_failed++; $display("FAIL wr_rdata_kept: got %h expected %h", dfp_rdata, LINE_A); end
    endtask

    task automatic test_read_stall();
        int rd, rc, rn;
        logic [31:0] a;
        logic [255:0] l;
        run_read(32'hCAFE_BABF, LINE_B, 3, 2, 0, 2, rd, rc, rn, a, l);
        tests_run++; if (rd !== 4) begin tests_failed++; $display("FAIL rds_read_cycles: got %0d expected 4", rd); end
        tests_run++; if (a !== 32'hCAFE_BAA0) begin tests_failed++; $display("FAIL rds_addr: got %h expected cafebaa0", a); end
        tests_run++; if (rn !== 1) begin tests_failed++; $display("FAIL rds_resp_count: got %0d expected 1", rn); end
        tests_run++; if (rc !== 17) begin tests_failed++; $display("FAIL rds_latency: got %0d expected 17", rc); end
        tests_run++; if (l !== LINE_B) begin tests_failed++; $display("FAIL rds_line: got %h expected %h", l, LINE_B); end
    endtask

    task automatic test_reset_mid_burst();
        int rd, rc, rn, spurious;
        logic [31:0] a;
        logic [255:0] l;
        run_read(32'h0000_4000, LINE_D, 0, 0, 2, 2, rd, rc, rn, a, l);
        mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++; if (rn !== 0) begin tests_failed++; $display("FAIL rst_mid_early_resp: got %0d expected 0", rn); end
        tests_run++; if (dfp_rdata !== 256'd0 || dfp_resp !== 1'b0 || mem_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_outputs: rdata %h resp %b addr %h expected zeros", dfp_rdata, dfp_resp, mem_addr); end
        tests_run++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_wdata !== 64'd0) begin tests_failed++; $display("FAIL rst_mid_mem: read %b write %b wdata %h expected zeros", mem_read, mem_write, mem_wdata); end
        tick();
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dfp_resp) spurious++;
        end
        tests_run++; if (spurious !== 0) begin tests_failed++; $display("FAIL rst_mid_no_resp: got %0d expected 0", spurious); end
        run_read(32'h0000_4008, LINE_C, 0, 0, 0, 2, rd, rc, rn, a, l);
        tests_run++; if (l !== LINE_C || rc !== 6 || rn !== 1) begin tests_failed++; $display("FAIL rst_mid_recover: line %h cycle %0d resps %0d expected %h 6 1", l, rc, rn, LINE_C); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] ws, l;
        logic [63:0] sf, sl;
        int ba, rc, rn, rd;
        logic [31:0] a;
        bit st;
        mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        tests_run++; if (dfp_rdata !== LINE_C) begin tests_failed++; $display("FAIL idle_stray_rvalid: got %h expected %h", dfp_rdata, LINE_C); end
        tests_run++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL idle_stray_ready: read %b write %b expected 0 0", mem_read, mem_write); end
        run_write(32'h8000_0040, WLINE, -1, 0, 1, ws, sf, sl, ba, rc, rn, a, st);
        tests_run++; if (rc !== 5 || rn !== 1 || ws !== WLINE) begin tests_failed++; $display("FAIL b2b_write: cycle %0d resps %0d data %h expected 5 1 %h", rc, rn, ws, WLINE); end
        tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL b2b_rdata_kept: got %b expected 1", st); end
        run_read(32'h8000_0060, LINE_D, 0, 0, 0, 2, rd, rc, rn, a, l);
        tests_run++; if (rc !== 6 || rn !== 1) begin tests_failed++; $display("FAIL b2b_read_latency: cycle %0d resps %0d expected 6 1", rc, rn); end
        tests_run++; if (l !== LINE_D) begin tests_failed++; $display("FAIL b2b_read_line: got %h expected %h", l, LINE_D); end
    endtask

    task automatic test_read_then_write();
        logic [255:0] ws, l;
        logic [63:0] sf, sl;
        int ba, rc, rn, rd;
        logic [31:0] a;
        bit st;
        run_read(32'h0BAD_F00D, LINE_E, 1, 1, 0, 2, rd, rc, rn, a, l);
        tests_run++; if (l !== LINE_E) begin tests_failed++; $display("FAIL rtw_read_line: got %h expected %h", l, LINE_E); end
        run_write(32'h0BAD_F000, ~WLINE, 2, 3, 2, ws, sf, sl, ba, rc, rn, a, st);
        tests_run++; if (ws !== ~WLINE || rn !== 1) begin tests_failed++; $display("FAIL rtw_write: data %h resps %0d expected %h 1", ws, rn, ~WLINE); end
        tests_run++; if (st !== 1'b1 || dfp_rdata !== LINE_E) begin tests_failed++; $display("FAIL rtw_rdata_kept: got %h expected %h", dfp_rdata, LINE_E); end
    endtask

    initial begin
        test_reset();
        test_read_zero_stall();
        test_write_stall();
        test_read_stall();
        test_reset_mid_burst();
        test_back_to_back();
        test_read_then_write();
        tests_run++; if (illegal_cnt !== 0) begin tests_failed++; $display("FAIL both_requests: got %0d expected 0", illegal_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
